// File: rtl/traffic_timer_sense.sv
// traffic_timer_sense: conditions the raw north/south vehicle sensors and
// times the light phases and the long-wait interval for the intersection
// light controller.
module traffic_timer_sense #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RED_CYCLES      = 2,
  parameter int GREEN_CYCLES    = 8,
  parameter int YELLOW_CYCLES   = 3,
  parameter int LONG_CYCLES     = 32,
  parameter int CW              = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SN,
  input  logic       SS,
  input  logic       phase_start,
  input  logic [1:0] phase_kind,
  input  logic       long_clr,
  output logic       SN_db,
  output logic       SS_db,
  output logic       S,
  output logic       T,
  output logic       L
);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RED_LAST    = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LIMIT  = CW'(LONG_CYCLES);

  logic [1:0] raw;
  logic [1:0] db_out;

  assign raw = {SS, SN};

  // One synchronizer + debouncer per sensor; index 0 is north, 1 is south.
  for (genvar i = 0; i < 2; i++) begin : g_sense
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop chain, then a run-length counter that commits the new level
    // only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
      sync1_d = raw[i];
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_LAST) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    // Sensor conditioning state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
      end
    end

    assign db_out[i] = db_q;
  end

  assign SN_db = db_out[0];
  assign SS_db = db_out[1];
  assign S     = SN_db | SS_db;

  logic [CW-1:0] phase_cnt_q, phase_cnt_d;
  logic [CW-1:0] phase_load;
  logic          t_q, t_d;

  // Phase timer: reload on phase_start, count down, then latch expiry in T.
  always_comb begin
    case (phase_kind)
      2'b01:   phase_load = GREEN_LAST;
      2'b10:   phase_load = YELLOW_LAST;
      default: phase_load = RED_LAST;
    endcase
    phase_cnt_d = phase_cnt_q;
    t_d         = t_q;
    if (phase_start) begin
      phase_cnt_d = phase_load;
      t_d         = 1'b0;
    end else if (phase_cnt_q != '0) begin
      phase_cnt_d = phase_cnt_q - CNT_ONE;
    end else begin
      t_d = 1'b1;
    end
  end

  // Reset starts an implicit red phase so the controller always sees T rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt_q <= RED_LAST;
      t_q         <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      t_q         <= t_d;
    end
  end

  assign T = t_q;

  logic [CW-1:0] long_cnt_q, long_cnt_d;
  logic          l_q, l_d;

  // Long-wait timer: saturating up-counter, cleared by long_clr; L flags saturation.
  always_comb begin
    long_cnt_d = long_cnt_q;
    if (long_clr) begin
      long_cnt_d = '0;
    end else if (long_cnt_q != LONG_LIMIT) begin
      long_cnt_d = long_cnt_q + CNT_ONE;
    end
    l_d = (long_cnt_d == LONG_LIMIT);
  end

  // Long-wait state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt_q <= '0;
      l_q        <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      l_q        <= l_d;
    end
  end

  assign L = l_q;

endmodule

// File: doc/traffic_timer_sense.md
Name: traffic_timer_sense

Overview:
- Front-end conditioning and timing stage that feeds the intersection light controller.
- Synchronizes and debounces the raw north/south vehicle sensors (SN, SS).
- Produces the phase timer-expired flag T and the long-wait flag L, which the controller's next-state logic consumes.
- The controller drives phase_start/phase_kind on every state entry and long_clr when it serves a long wait.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles before a sensor output changes (min 1)
RED_CYCLES, 2, all-red clearance phase duration in clk cycles (min 1)
GREEN_CYCLES, 8, green phase duration in clk cycles (min 1)
YELLOW_CYCLES, 3, yellow phase duration in clk cycles (min 1)
LONG_CYCLES, 32, cycles after long_clr before L asserts (min 1)
CW, 8, width of all internal counters; must hold max(all durations, LONG_CYCLES)

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
SN  in  1  raw north sensor, asynchronous to clk
SS  in  1  raw south sensor, asynchronous to clk
phase_start  in  1  one-cycle pulse: controller entered a new phase
phase_kind  in  2  phase type, sampled with phase_start: 00 red, 01 green, 10 yellow, 11 treated as red
long_clr  in  1  one-cycle pulse: restart the long-wait timer
SN_db  out  1  debounced north sensor
SS_db  out  1  debounced south sensor
S  out  1  SN_db | SS_db (combinational from registers)
T  out  1  phase timer expired; level, held until next phase_start
L  out  1  long-wait elapsed; level, held until long_clr

Behaviour:
- Reset (async assert, sync-released use):
  - Synchronizer flops, debounce counters, SN_db, SS_db, L and the long counter all go to 0.
  - Phase counter loads RED_CYCLES-1 and T = 0, i.e. an implicit red phase starts at reset, so the controller cannot deadlock waiting on T.
- Synchronizer: 2-flop chain per sensor. Latency from a raw edge to the synchronized value is 2 edges.
- Debounce, per sensor, independent:
  - The counter increments each cycle the synchronized value differs from the _db output.
  - The counter clears to 0 on any cycle they agree.
  - When the counter reaches DEBOUNCE_CYCLES, _db takes the synchronized value on the same edge and the counter clears.
  - Total latency for a clean raw edge is 2 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches _db.
- Phase timer:
  - Duration N = RED_CYCLES, GREEN_CYCLES or YELLOW_CYCLES per phase_kind.
  - Edge e0 with phase_start = 1: counter loads N-1 and T clears to 0.
  - Later edges: if counter != 0 it decrements; else T sets to 1.
  - T therefore rises exactly N edges after e0 and stays 1; the counter stays at 0.
  - phase_start while T = 1: reload, T = 0 from the next cycle.
  - phase_start mid-count: restart with the new duration, no residual expiry.
- Long timer:
  - The counter increments by 1 per cycle and saturates at LONG_CYCLES.
  - L = (counter == LONG_CYCLES), registered.
  - long_clr sets counter = 0 and L = 0 on that edge; L rises LONG_CYCLES edges later.
  - long_clr coinciding with saturation: clear wins.
  - long_clr held high: L stays 0.
- Simultaneous events: phase_start and long_clr in the same cycle are independent; both take effect.
- The counters never wrap; widths are guaranteed by CW.
- Reset mid-operation: all state returns to the reset values immediately (async). No pending expiry or debounce progress survives.

Test Plan:
- Reset, then no phase_start -> T = 0 for 1 edge after release, T = 1 from the 2nd edge (RED_CYCLES = 2); SN_db = SS_db = L = 0.
- phase_start with phase_kind = 01 at edge 10 -> T = 0 at edges 10–17, T = 1 at edge 18 and held through edge 30. Then phase_kind = 10 pulse -> T = 1 again exactly 3 edges later.
- Raw SN high for 10 cycles -> SN_db = 1 and S = 1 at edge 6 after the raw rise. Raw SS high for 3 cycles only -> SS_db remains 0.
- Raw SN toggling every 2 cycles for 20 cycles -> SN_db never changes. Then SN steady high -> SN_db rises 6 edges later.
- long_clr at edge 0 -> L = 1 at edge 32, held. long_clr at edge 40 -> L = 0 at edge 41, rises again at edge 72.
- phase_start (green) at edge 5, then again at edge 9 with phase_kind = 11 -> no T at edge 13; T rises at edge 11 (red, N = 2). Assert reset_n = 0 mid-count -> T, L and the _db outputs go to 0 immediately.
